// File: rtl/bsa_pkg.sv
// rtl/bsa_pkg.sv - shared types and constants for the bit-serial adder controller
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bsa_state_e;

  localparam int BSA_DEFAULT_WIDTH = 8;

  // Counter must address bits 0..WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int bsa_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational sum/carry cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - LSB-first bit-serial adder with valid/ready request and result handshakes
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = BSA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int             CW   = bsa_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  bsa_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q;

  logic fa_a, fa_b, fa_s, fa_cout;

  assign fa_a = a_q[cnt_q];
  assign fa_b = b_q[cnt_q];

  full_adder u_cell (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // The counter holds at LAST on the final RUN edge so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            res_q   <= '0;
          end
        end
        RUN: begin
          res_q[cnt_q] <= fa_s;
          carry_q      <= fa_cout;
          if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = (state_q == DONE) ? res_q : '0;
  assign cout = (state_q == DONE) ? carry_q : 1'b0;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// tb/tb_bit_serial_adder_ctrl.sv - self-checking bench for bit_serial_adder_ctrl at WIDTH=8
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int errors;
  int checks;
  int req_hs;
  int out_hs;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) req_hs++;
    if (rst_n && out_valid && out_ready) out_hs++;
  end

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
  endfunction

  // One full operation: request, latency check, optional disturbance and backpressure, output handshake.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input bit disturb, input int bp, input string name);
    logic [W:0] exp;
    logic [W:0] held;
    bit         early;
    bit         unstable;
    exp = model_add(av, bv, cv);
    a = av; b = bv; cin = cv; in_valid = 1'b1; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: in_ready=%b expected 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    early = 1'b0;
    for (int k = 1; k < W; k++) begin
      if (disturb) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid !== 1'b0) early = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s_latency: out_valid rose before edge E0+%0d", name, W);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || {cout, sum} !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_result: out_valid=%b cout/sum=%h in_ready=%b busy=%b expected 1 %h 0 1",
               name, out_valid, {cout, sum}, in_ready, busy, exp);
    end
    held = {cout, sum};
    unstable = 1'b0;
    for (int j = 0; j < bp; j++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || {cout, sum} !== held || in_ready !== 1'b0) unstable = 1'b1;
    end
    if (bp > 0) begin
      checks++;
      if (unstable) begin
        errors++;
        $display("FAIL %s_backpressure: out_valid=%b cout/sum=%h in_ready=%b expected 1 %h 0",
                 name, out_valid, {cout, sum}, in_ready, held);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b sum=%h cout=%b busy=%b in_ready=%b expected 0 00 0 0 1",
               out_valid, sum, cout, busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0, "basic");
  endtask

  task automatic test_carry();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, "carry_ripple");
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, "carry_all_ones");
    do_op(8'h00, 8'h00, 1'b1, 1'b0, 0, "carry_in_only");
  endtask

  task automatic test_backpressure();
    do_op(8'h81, 8'h7F, 1'b1, 1'b0, 5, "backpressure");
  endtask

  task automatic test_disturbance();
    do_op(8'hA5, 8'h5B, 1'b1, 1'b1, 0, "disturb1");
    do_op(8'h13, 8'hC7, 1'b0, 1'b1, 2, "disturb2");
  endtask

  task automatic test_reset_mid();
    bit spurious;
    a = 8'h44; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state: out_valid=%b sum=%h busy=%b in_ready=%b expected 0 00 0 1",
               out_valid, sum, busy, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL reset_mid_discard: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    do_op(8'h9E, 8'h6D, 1'b1, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av, bv;
    logic         cv;
    logic [W:0]   exp;
    int           bad;
    int           timeouts;
    int           base_req;
    int           base_out;
    bit           got_req;
    bit           got_out;
    bad = 0; timeouts = 0;
    base_req = req_hs; base_out = out_hs;
    for (int i = 0; i < 1000; i++) begin
      av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
      exp = model_add(av, bv, cv);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      got_req = 1'b0;
      for (int t = 0; t < 50 && !got_req; t++) begin
        out_ready = 1'($urandom);
        @(negedge clk);
        if (in_ready) got_req = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      got_out = 1'b0;
      for (int t = 0; t < 100 && !got_out; t++) begin
        out_ready = 1'($urandom);
        @(negedge clk);
        if (out_valid && out_ready) begin
          got_out = 1'b1;
          if ({cout, sum} !== exp) begin
            bad++;
            if (bad <= 5)
              $display("FAIL regress_result: op %0d cout/sum=%h expected %h", i, {cout, sum}, exp);
          end
        end
        @(posedge clk); #1;
      end
      if (!got_req || !got_out) timeouts++;
    end
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL regress_results: mismatching results=%0d expected 0", bad);
    end
    checks++;
    if (timeouts != 0) begin
      errors++;
      $display("FAIL regress_timeout: stalled operations=%0d expected 0", timeouts);
    end
    checks++;
    if ((req_hs - base_req) != 1000 || (out_hs - base_out) != 1000) begin
      errors++;
      $display("FAIL regress_handshakes: requests=%0d outputs=%0d expected 1000 1000",
               req_hs - base_req, out_hs - base_out);
    end
  endtask

  initial begin
    errors = 0; checks = 0; req_hs = 0; out_hs = 0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_disturbance();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder_ctrl.md
BIT_SERIAL_ADDER_CTRL -- requirements
Module: bit_serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  controller can accept an operand request.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result sum.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in RUN and DONE states.

Function
REQ-014 The controller SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0.
  - Request handshake (in_valid & in_ready at an edge): latch a, b and cin into internal registers.
  - Clear the bit counter and the result shift register; go to RUN.
REQ-016 RUN: in_ready=0 and out_valid=0.
  - Each cycle, apply bit[cnt] of the latched A and B plus the carry register to one 1-bit full-adder cell.
  - Store the sum bit at result position cnt; load the carry register with the cell's carry; increment cnt.
REQ-017 RUN SHALL process LSB first.
  - Exactly WIDTH RUN cycles.
  - The edge on which cnt==WIDTH-1 SHALL move the state to DONE.
REQ-018 DONE: out_valid=1; sum = accumulated result; cout = final carry register.
  - sum and cout SHALL hold stable until the output handshake.
REQ-019 Output handshake (out_valid & out_ready at an edge) SHALL return the state to IDLE.
REQ-020 Latency: request handshake at edge E0; out_valid SHALL be observed high after edge E0+WIDTH.
  - Minimum spacing between accepted requests: WIDTH+2 cycles.
REQ-021 Changes on a, b, cin or in_valid while busy SHALL have no effect on the result in progress.
REQ-022 out_ready while not in DONE SHALL be ignored.
REQ-023 in_valid is not accepted in DONE, even when out_ready is high in the same cycle.
  - No request/output overlap.
REQ-024 Arithmetic: {cout,sum} SHALL equal a + b + cin, computed modulo 2^(WIDTH+1).
REQ-025 WIDTH=1: exactly one RUN cycle; the result SHALL equal a single full-adder evaluation.
REQ-026 The bit counter SHALL be max(1,$clog2(WIDTH)) bits wide and SHALL never wrap during RUN.

Reset
REQ-027 rst_n low SHALL asynchronously force the following:
  - state IDLE; cnt 0; carry register 0; operand and result registers 0.
  - Outputs: out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
REQ-028 Reset asserted in RUN or DONE SHALL discard the operation in progress.
  - No out_valid pulse SHALL follow reset release.
REQ-029 After reset release, a request SHALL be accepted on the first rising edge at which in_valid is high.

Structure
REQ-030 Shared package bsa_pkg SHALL hold:
  - the state enum typedef (IDLE, RUN, DONE);
  - the default WIDTH constant.
REQ-031 The 1-bit sum/carry cell SHALL be a separate sub-module, full_adder (ports a, b, cin, s, cout), instantiated once.
REQ-032 All sequencing SHALL reside in bit_serial_adder_ctrl; the cell SHALL be purely combinational.

Verification (WIDTH=8)
REQ-033 Basic add: a=0x5A, b=0x3C, cin=0 accepted at edge E0.
  - sum=0x96, cout=0, out_valid high after edge E0+8.
REQ-034 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
  - Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1; sum/cout stable; in_ready stays 0.
  - A new in_valid during this time is not accepted.
REQ-036 Input disturbance: toggle a, b and cin every cycle during RUN -> result matches the operands latched at the request handshake.
REQ-037 Reset mid-operation: assert rst_n=0 after 3 RUN cycles.
  - Immediately: out_valid=0, sum=0, busy=0.
  - After release: in_ready=1; the next request completes correctly.
REQ-038 Random regression: 1000 back-to-back requests with random out_ready.
  - Every result matches a+b+cin.
  - The request/output handshake count matches.
